// File: rtl/rk_sram_arb.sv
// Three-port SRAM sequencer for Radio-86RK main memory: video > CPU > aux, with aux anti-starvation.
// Define RK_SRAM_WRPROT_EN to block CPU/aux writes at or above WP_BASE.
module rk_sram_arb #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned ACC_CYC    = 3,
  parameter int unsigned STARVE_MAX = 8
`ifdef RK_SRAM_WRPROT_EN
  ,
  parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(15'h7600)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_we_n
);

  localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
  localparam logic [3:0]    LAST_K     = 4'(ACC_CYC - 1);
  localparam logic [3:0]    WE_END     = 4'(ACC_CYC - 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic [1:0] {PortVid, PortCpu, PortAux} port_e;

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              drive_q, drive_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;
  logic [2:0]        ack_q, ack_d;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    drive_d  = drive_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (vid_req || cpu_req || aux_req) begin
          state_d = StAccess;
          cnt_d   = '0;
          if (vid_req) begin
            port_d = PortVid;
          end else if (aux_req && (!cpu_req || starve_q == STARVE_TOP)) begin
            port_d = PortAux;
          end else begin
            port_d = PortCpu;
          end
          unique case (port_d)
            PortVid: begin
              addr_d = vid_addr;
              we_d   = 1'b0;
            end
            PortCpu: begin
              addr_d  = cpu_addr;
              we_d    = cpu_we;
              wdata_d = cpu_wdata;
            end
            default: begin
              addr_d  = aux_addr;
              we_d    = aux_we;
              wdata_d = aux_wdata;
            end
          endcase
`ifdef RK_SRAM_WRPROT_EN
          drive_d = we_d && (addr_d < WP_BASE);
`else
          drive_d = we_d;
`endif
          if (port_d == PortAux) begin
            starve_d = '0;
          end else if (aux_req && starve_q != STARVE_TOP) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_K) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = sram_dq_i;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Pad controls are registered from next state so they are glitch-free at the pins.
    oe_d   = (state_d == StAccess) && drive_d;
    we_n_d = !(oe_d && (cnt_d >= 4'd1) && (cnt_d <= WE_END));
    ack_d  = {(state_d == StDone) && (port_d == PortAux),
              (state_d == StDone) && (port_d == PortCpu),
              (state_d == StDone) && (port_d == PortVid)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      port_q   <= PortVid;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      drive_q  <= 1'b0;
      starve_q <= '0;
      rdata_q  <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      drive_q  <= drive_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      ack_q    <= ack_d;
    end
  end

  assign vid_ack    = ack_q[0];
  assign cpu_ack    = ack_q[1];
  assign aux_ack    = ack_q[2];
  assign rdata      = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_rk_sram_arb.sv
// Bench for rk_sram_arb: table vectors, corner sequences and randomized batches
// checked against a transaction-level arbitration/memory model.
module tb_rk_sram_arb;

  localparam int ACC    = 3;
  localparam int STARVE = 8;

  typedef struct {
    int          port;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct {
    int          port;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
    int          exp_we_low;
    int          exp_oe;
  } vec_t;

  logic clk, reset;
  logic vid_req, cpu_req, cpu_we, aux_req, aux_we;
  logic [14:0] vid_addr, cpu_addr, aux_addr;
  logic [7:0] cpu_wdata, aux_wdata;
  logic vid_ack, cpu_ack, aux_ack;
  logic [7:0] rdata, sram_dq_o, sram_dq_i;
  logic [14:0] sram_addr;
  logic sram_dq_oe, sram_we_n;

  logic vid_req5;
  logic [14:0] vid_addr5, sram_addr5;
  logic vid_ack5, cpu_ack5, aux_ack5, sram_dq_oe5, sram_we_n5;
  logic [7:0] rdata5, sram_dq_o5, sram_dq_i5;

  logic [7:0] mem [0:32767];
  logic [7:0] ref_mem [0:32767];

  int checks = 0;
  int passed = 0;
  int we_low_total = 0, oe_total = 0, viol_total = 0, oe5_total = 0, we5_total = 0;

  txn_t qv[$], qc[$], qa[$];
  int exp_p[$], exp_t[$];
  logic [7:0] exp_r[$];
  int obs_p[$], obs_t[$];
  logic [7:0] obs_r[$];
  int exp_we_low, exp_oe, last_we_low, last_oe;
  logic [7:0] m_rdata;
  int m_starve;
  vec_t vecs[11];

  rk_sram_arb #(.ADDR_W(15), .ACC_CYC(ACC), .STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack),
    .rdata(rdata), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
  );

  rk_sram_arb #(.ADDR_W(15), .ACC_CYC(5), .STARVE_MAX(STARVE)) u_dut5 (
    .clk(clk), .reset(reset),
    .vid_req(vid_req5), .vid_addr(vid_addr5), .vid_ack(vid_ack5),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(15'h0), .cpu_wdata(8'h0), .cpu_ack(cpu_ack5),
    .aux_req(1'b0), .aux_we(1'b0), .aux_addr(15'h0), .aux_wdata(8'h0), .aux_ack(aux_ack5),
    .rdata(rdata5), .sram_addr(sram_addr5), .sram_dq_o(sram_dq_o5), .sram_dq_oe(sram_dq_oe5),
    .sram_dq_i(sram_dq_i5), .sram_we_n(sram_we_n5)
  );

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ a[14:7];
  endfunction

  function automatic bit prot(input txn_t tx);
`ifdef RK_SRAM_WRPROT_EN
    return tx.we && (tx.addr >= 15'h7600);
`else
    return 1'b0;
`endif
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: written mid-cycle while we_n is low.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
    forever begin
      @(negedge clk);
      if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_o;
    end
  end
  assign sram_dq_i  = mem[sram_addr];
  assign sram_dq_i5 = pat(sram_addr5);

  always @(negedge clk) begin
    if (!sram_we_n) we_low_total <= we_low_total + 1;
    if (sram_dq_oe) oe_total <= oe_total + 1;
    if (!sram_we_n && !sram_dq_oe) viol_total <= viol_total + 1;
    if (sram_dq_oe5) oe5_total <= oe5_total + 1;
    if (!sram_we_n5) we5_total <= we5_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All queued transactions are visible from cycle 0; each IDLE decision takes the best waiting port.
  task automatic predict();
    txn_t mv[$], mc[$], ma[$];
    txn_t tx;
    int t, p;
    mv = qv; mc = qc; ma = qa;
    exp_p.delete(); exp_t.delete(); exp_r.delete();
    exp_we_low = 0; exp_oe = 0; t = 0;
    while (mv.size() + mc.size() + ma.size() > 0) begin
      if (mv.size() > 0) p = 0;
      else if (ma.size() > 0 && (m_starve == STARVE || mc.size() == 0)) p = 2;
      else p = 1;
      if (p == 2) m_starve = 0;
      else if (ma.size() > 0 && m_starve < STARVE) m_starve++;
      if (p == 0) tx = mv.pop_front();
      else if (p == 1) tx = mc.pop_front();
      else tx = ma.pop_front();
      if (tx.we) begin
        if (!prot(tx)) begin
          ref_mem[tx.addr] = tx.wdata;
          exp_we_low += ACC - 2;
          exp_oe += ACC;
        end
      end else begin
        m_rdata = ref_mem[tx.addr];
      end
      exp_p.push_back(p);
      exp_t.push_back(t + ACC + 1);
      exp_r.push_back(m_rdata);
      t += ACC + 2;
    end
  endtask

  task automatic apply_heads();
    vid_req = (qv.size() > 0);
    if (qv.size() > 0) vid_addr = qv[0].addr;
    cpu_req = (qc.size() > 0);
    if (qc.size() > 0) begin
      cpu_we = qc[0].we; cpu_addr = qc[0].addr; cpu_wdata = qc[0].wdata;
    end
    aux_req = (qa.size() > 0);
    if (qa.size() > 0) begin
      aux_we = qa[0].we; aux_addr = qa[0].addr; aux_wdata = qa[0].wdata;
    end
  endtask

  task automatic push(input int port, input logic we, input logic [14:0] addr,
                      input logic [7:0] wdata);
    txn_t tx;
    tx.port = port; tx.we = (port == 0) ? 1'b0 : we; tx.addr = addr; tx.wdata = wdata;
    if (port == 0) qv.push_back(tx);
    else if (port == 1) qc.push_back(tx);
    else qa.push_back(tx);
  endtask

  // Must be entered in an IDLE cycle; leaves the DUT in an IDLE cycle.
  task automatic run_queues(input string name);
    int t, n, total, budget, p, hits, wl0, oe0;
    predict();
    total = exp_p.size();
    budget = total * (ACC + 2) + 10;
    obs_p.delete(); obs_t.delete(); obs_r.delete();
    wl0 = we_low_total; oe0 = oe_total;
    t = 0; n = 0;
    apply_heads();
    while (n < total && t < budget) begin
      tick();
      t++;
      hits = int'(vid_ack) + int'(cpu_ack) + int'(aux_ack);
      p = vid_ack ? 0 : (cpu_ack ? 1 : (aux_ack ? 2 : -1));
      if (hits > 1) chk({name, "_one_ack"}, hits, 1);
      if (p >= 0) begin
        chk({name, "_port"}, p, exp_p[n]);
        chk({name, "_cycle"}, t, exp_t[n]);
        chk({name, "_rdata"}, rdata, exp_r[n]);
        obs_p.push_back(p); obs_t.push_back(t); obs_r.push_back(rdata);
        if (p == 0 && qv.size() > 0) void'(qv.pop_front());
        if (p == 1 && qc.size() > 0) void'(qc.pop_front());
        if (p == 2 && qa.size() > 0) void'(qa.pop_front());
        n++;
        apply_heads();
      end
    end
    chk({name, "_acks_seen"}, n, total);
    qv.delete(); qc.delete(); qa.delete();
    apply_heads();
    tick();
    last_we_low = we_low_total - wl0;
    last_oe = oe_total - oe0;
    chk({name, "_we_low_cycles"}, last_we_low, exp_we_low);
    chk({name, "_oe_cycles"}, last_oe, exp_oe);
  endtask

  task automatic starvation_test();
    int aux_pos[$];
    for (int i = 0; i < 18; i++) push(1, 1'b0, 15'(16'h0300 + i), 8'h00);
    push(2, 1'b0, 15'h0123, 8'h00);
    push(2, 1'b0, 15'h0200, 8'h00);
    run_queues("starve");
    for (int i = 0; i < obs_p.size(); i++) if (obs_p[i] == 2) aux_pos.push_back(i);
    chk("starve_first_aux_pos", aux_pos.size() > 0 ? aux_pos[0] : -1, 8);
    chk("starve_second_aux_pos", aux_pos.size() > 1 ? aux_pos[1] : -1, 17);
  endtask

  task automatic reset_abort_test();
    int seen;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0040; cpu_wdata = 8'hEE;
    tick();
    tick();
    chk("abort_k2_we_n", sram_we_n, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("abort_we_n", sram_we_n, 1'b1);
    chk("abort_oe", sram_dq_oe, 1'b0);
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    m_rdata = 8'h00; m_starve = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(cpu_ack) + int'(vid_ack) + int'(aux_ack);
    end
    chk("abort_no_ack", seen, 0);
    chk("abort_rdata", rdata, 8'h00);
    chk("abort_sram_addr", sram_addr, 15'h0);
    push(1, 1'b0, 15'h0040, 8'h00);
    run_queues("after_abort");
    chk("after_abort_data", obs_r.size() > 0 ? obs_r[0] : 8'hXX, pat(15'h0040));
  endtask

  task automatic acc5_test();
    int t, oe0, we0;
    bit got;
    oe0 = oe5_total; we0 = we5_total;
    vid_addr5 = 15'h1234;
    vid_req5 = 1'b1;
    t = 0; got = 1'b0;
    while (!got && t < 30) begin
      tick();
      t++;
      if (vid_ack5) got = 1'b1;
    end
    vid_req5 = 1'b0;
    chk("acc5_latency", t, 6);
    chk("acc5_rdata", rdata5, pat(15'h1234));
    tick();
    chk("acc5_oe_cycles", oe5_total - oe0, 0);
    chk("acc5_we_low_cycles", we5_total - we0, 0);
  endtask

  initial begin
    vid_req = 0; cpu_req = 0; aux_req = 0; cpu_we = 0; aux_we = 0;
    vid_addr = 0; cpu_addr = 0; aux_addr = 0; cpu_wdata = 0; aux_wdata = 0;
    vid_req5 = 0; vid_addr5 = 0;
    m_rdata = 8'h00; m_starve = 0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pat(15'(i));

    vecs[0]  = '{1, 1'b1, 15'h0123, 8'hA5, 8'h00, 4, 1, 3};
    vecs[1]  = '{1, 1'b0, 15'h0123, 8'h00, 8'hA5, 4, 0, 0};
    vecs[2]  = '{2, 1'b1, 15'h0200, 8'h3C, 8'hA5, 4, 1, 3};
    vecs[3]  = '{0, 1'b0, 15'h0200, 8'h00, 8'h3C, 4, 0, 0};
    vecs[4]  = '{2, 1'b0, 15'h0123, 8'h00, 8'hA5, 4, 0, 0};
    vecs[5]  = '{1, 1'b1, 15'h0123, 8'h5A, 8'hA5, 4, 1, 3};
    vecs[6]  = '{0, 1'b0, 15'h0123, 8'h00, 8'h5A, 4, 0, 0};
    vecs[7]  = '{2, 1'b1, 15'h7000, 8'hC3, 8'h5A, 4, 1, 3};
    vecs[8]  = '{1, 1'b0, 15'h7000, 8'h00, 8'hC3, 4, 0, 0};
    vecs[9]  = '{2, 1'b0, 15'h0200, 8'h00, 8'h3C, 4, 0, 0};
    vecs[10] = '{0, 1'b0, 15'h0005, 8'h00, 8'h05, 4, 0, 0};

    reset = 1'b1;
    tick(); tick();
    chk("rst_acks", {vid_ack, cpu_ack, aux_ack}, 3'b000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_sram_addr", sram_addr, 15'h0);
    chk("rst_dq_o", sram_dq_o, 8'h00);
    chk("rst_oe", sram_dq_oe, 1'b0);
    chk("rst_we_n", sram_we_n, 1'b1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      push(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      run_queues("tbl");
      chk("tbl_latency", obs_t.size() > 0 ? obs_t[0] : -1, vecs[i].exp_lat);
      chk("tbl_rdata", obs_r.size() > 0 ? obs_r[0] : 8'hXX, vecs[i].exp_rdata);
      chk("tbl_we_low", last_we_low, vecs[i].exp_we_low);
      chk("tbl_oe", last_oe, vecs[i].exp_oe);
      chk("tbl_sram_addr_hold", sram_addr, vecs[i].addr);
    end

`ifdef RK_SRAM_WRPROT_EN
    push(1, 1'b1, 15'h7600, 8'h55);
    run_queues("wp_write");
    chk("wp_acked", obs_p.size(), 1);
    chk("wp_we_low", last_we_low, 0);
    chk("wp_oe", last_oe, 0);
    push(1, 1'b0, 15'h7600, 8'h00);
    run_queues("wp_read");
    chk("wp_readback", obs_r.size() > 0 ? obs_r[0] : 8'hXX, pat(15'h7600));
`endif

    push(0, 1'b0, 15'h0200, 8'h00);
    push(1, 1'b0, 15'h0123, 8'h00);
    run_queues("vid_cpu");
    chk("vid_cpu_first", obs_p.size() > 0 ? obs_p[0] : -1, 0);
    chk("vid_cpu_second", obs_p.size() > 1 ? obs_p[1] : -1, 1);
    chk("vid_cpu_gap", obs_t.size() > 1 ? obs_t[1] - obs_t[0] : -1, 5);

    reset_abort_test();
    starvation_test();
    acc5_test();

    for (int b = 0; b < 40; b++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) begin
            logic [14:0] a;
            a = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
            push(p, 1'($urandom_range(0, 1)), a, 8'($urandom));
          end
        end
      end
      if (qv.size() + qc.size() + qa.size() == 0) push(1, 1'b0, 15'h0001, 8'h00);
      run_queues("rand");
    end

    chk("we_n_without_oe", viol_total, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rk_sram_arb.md
Name: rk_sram_arb

Overview:
- Three-port arbiter/sequencer for the single 8-bit asynchronous SRAM holding Radio-86RK main memory.
- Ports, highest priority first:
  - video DMA read port;
  - CPU port;
  - aux port (SD/tape loader, memory fill).
- Owns all SRAM pins: address, data-out enable, write strobe timing. Returns read data with a one-cycle ack pulse per port.
- Sits between the CPU/DMA address muxing and the SRAM pads.

Parameters:
- ADDR_W, 15, SRAM word address width.
- ACC_CYC, 3, clock cycles per SRAM access; legal range 3..15.
- STARVE_MAX, 8, lost aux arbitrations before aux is promoted above CPU.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request, level, held until vid_ack.
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  one-cycle pulse; rdata valid in this cycle.
- cpu_req  in  1  CPU request, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- aux_req, aux_we, aux_addr, aux_wdata, aux_ack: as the CPU port, for aux.
- rdata  out  8  registered read data, shared by all ports.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_o  out  8  SRAM write data.
- sram_dq_oe  out  1  data pad output enable.
- sram_dq_i  in  8  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE;
  - all acks = 0; rdata = 0; sram_addr = 0; sram_dq_o = 0;
  - sram_dq_oe = 0; sram_we_n = 1; starvation counter = 0.
- A reset during an access aborts it: no ack is issued, and we_n and oe drop off the bus immediately.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE arbitration:
  - Samples requests and picks a winner: vid > cpu > aux.
  - Exception: if the starvation counter equals STARVE_MAX and aux_req=1, the order is vid > aux > cpu.
  - On a grant, latches the port id, addr, we and wdata, clears the cycle counter and enters ACCESS.
  - With no request, stays in IDLE and the outputs hold.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each IDLE grant to another port while aux_req=1.
  - Clears on an aux grant.
- ACCESS, counter k = 1..ACC_CYC:
  - sram_addr is driven from the latched address for every cycle of the access.
  - Write: sram_dq_oe=1 and sram_dq_o = latched data for all k. sram_we_n=0 only for k = 2..ACC_CYC-1, giving one cycle of setup and one of hold.
  - Read: oe=0 and we_n=1 throughout. rdata <= sram_dq_i at the k = ACC_CYC edge.
  - After k = ACC_CYC the FSM moves to DONE.
- DONE (exactly one cycle):
  - The granted port's ack = 1; rdata is valid.
  - oe=0, we_n=1. The next state is IDLE.
- Requester contract:
  - Deassert req (or present a new request) on the edge where ack=1, so that IDLE never re-grants a completed request.
  - Changing addr, we or wdata while req is held and not yet granted is allowed; values are latched at grant.
- Latency: req high in IDLE gives ack exactly ACC_CYC+1 cycles after the grant edge. Back-to-back throughput is one access per ACC_CYC+2 cycles.
- Simultaneous requests: the loser holds req and is served in a later IDLE. The video worst-case wait is one in-flight access.
- rdata is not modified by write accesses.
- sram_addr retains its last value in IDLE/DONE.

Optional Feature:
- Macro: RK_SRAM_WRPROT_EN.
- Defined:
  - Adds parameter WP_BASE (default 15'h7600).
  - CPU and aux writes with latched addr >= WP_BASE run the full ACCESS/DONE sequence and are acked normally, but sram_we_n stays 1 and sram_dq_oe stays 0 throughout.
- Undefined: all writes proceed; the WP_BASE parameter is absent.

Test Plan:
- CPU write 15'h0123 <= 8'hA5, then CPU read 15'h0123 with an SRAM model (ACC_CYC=3) -> we_n low exactly one cycle (k=2); read cpu_ack 4 cycles after grant with rdata=8'hA5.
- vid_req and cpu_req rise in the same cycle -> video granted first, vid_ack; CPU granted in the next IDLE, cpu_ack 5 cycles after vid_ack.
- cpu_req held continuously, aux_req high -> aux granted after exactly 8 CPU grants; counter then clears.
- reset asserted at k=2 of a write -> we_n=1 and oe=0 within the same cycle; no ack; the next request completes normally.
- Video read with ACC_CYC=5 -> vid_ack 6 cycles after grant; oe never asserted.
- RK_SRAM_WRPROT_EN, CPU write 15'h7600 <= 8'h55 -> cpu_ack pulses, we_n never low; readback returns the prior content.
